// File: rtl/alu_operand_loader.sv
// alu_operand_loader: gathers operand A, operand B, the select code and the
// carry-in from board switches over successive debounced load presses. The
// collected set is held in registers so the 2-bit ALU only ever sees a
// consistent operand set. A separate clear button restarts collection.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    input  logic       cin_sw,
    input  logic       btn_load,
    input  logic       btn_clr,
    output logic       a0,
    output logic       a1,
    output logic       b0,
    output logic       b1,
    output logic       Cin,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic       go,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        GET_A  = 2'b00,
        GET_B  = 2'b01,
        GET_OP = 2'b10,
        READY  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       ldSync_q;
    logic [1:0]       clrSync_q;
    logic             ldDb_q,    ldDb_d;
    logic             ldDbDly_q;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    state_e           state_q,   state_d;
    logic [1:0]       aOp_q,     aOp_d;
    logic [1:0]       bOp_q,     bOp_d;
    logic [1:0]       sel_q,     sel_d;
    logic             cin_q,     cin_d;
    logic             valid_q,   valid_d;
    logic             go_q,      go_d;

    logic ldS;
    logic clrS;
    logic press;

    assign ldS   = ldSync_q[1];
    assign clrS  = clrSync_q[1];
    assign press = ldDb_q & ~ldDbDly_q;

    // Debouncer: accept a new level once it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        ldDb_d = ldDb_q;
        cnt_d  = cnt_q;
        if (ldS == ldDb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            ldDb_d = ldS;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Collection FSM and operand capture; clear overrides any press in the same cycle
    always_comb begin
        state_d = state_q;
        aOp_d   = aOp_q;
        bOp_d   = bOp_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        go_d    = 1'b0;
        if (clrS) begin
            state_d = GET_A;
            aOp_d   = 2'b00;
            bOp_d   = 2'b00;
            sel_d   = 2'b00;
            cin_d   = 1'b0;
            valid_d = 1'b0;
        end else if (press) begin
            unique case (state_q)
                GET_A: begin
                    aOp_d   = sw;
                    state_d = GET_B;
                end
                GET_B: begin
                    bOp_d   = sw;
                    state_d = GET_OP;
                end
                GET_OP: begin
                    sel_d   = sw;
                    cin_d   = cin_sw;
                    valid_d = 1'b1;
                    go_d    = 1'b1;
                    state_d = READY;
                end
                READY: begin
                    valid_d = 1'b0;
                    aOp_d   = sw;
                    state_d = GET_B;
                end
                default: state_d = GET_A;
            endcase
        end
    end

    // All state registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldSync_q  <= 2'b00;
            clrSync_q <= 2'b00;
            ldDb_q    <= 1'b0;
            ldDbDly_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= GET_A;
            aOp_q     <= 2'b00;
            bOp_q     <= 2'b00;
            sel_q     <= 2'b00;
            cin_q     <= 1'b0;
            valid_q   <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            ldSync_q  <= {ldSync_q[0], btn_load};
            clrSync_q <= {clrSync_q[0], btn_clr};
            ldDb_q    <= ldDb_d;
            ldDbDly_q <= ldDb_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            aOp_q     <= aOp_d;
            bOp_q     <= bOp_d;
            sel_q     <= sel_d;
            cin_q     <= cin_d;
            valid_q   <= valid_d;
            go_q      <= go_d;
        end
    end

    assign a0    = aOp_q[0];
    assign a1    = aOp_q[1];
    assign b0    = bOp_q[0];
    assign b1    = bOp_q[1];
    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign Cin   = cin_q;
    assign valid = valid_q;
    assign go    = go_q;
    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed, table-driven bench for the operand loader,
// using a short debounce window so every press settles in a few cycles.
module tb_alu_operand_loader;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       cin_sw;
    logic       btn_load;
    logic       btn_clr;
    logic       a0, a1, b0, b1, Cin, s0, s1, valid, go;
    logic [1:0] state;

    int checks   = 0;
    int errors   = 0;
    int goCount  = 0;
    int goBase   = 0;
    logic prevValid = 1'b0;

    typedef struct {
        logic [1:0] sw;
        logic       cin;
        logic [9:0] expOut;
        int         expGo;
    } vec_t;

    vec_t vecs [6];

    alu_operand_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .cin_sw   (cin_sw),
        .btn_load (btn_load),
        .btn_clr  (btn_clr),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1),
        .Cin      (Cin),
        .s0       (s0),
        .s1       (s1),
        .valid    (valid),
        .go       (go),
        .state    (state)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs packed as {a1,a0,b1,b0,s1,s0,Cin,valid,state}
    function automatic logic [9:0] packOut();
        return {a1, a0, b1, b0, s1, s0, Cin, valid, state};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // A complete press: hold the button well past the debounce window, then release
    task automatic applyStimulus(input logic [1:0] swVal, input logic cinVal);
        @(negedge clk);
        sw       = swVal;
        cin_sw   = cinVal;
        btn_load = 1'b1;
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n    = 1'b0;
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        sw       = 2'b00;
        cin_sw   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // go must be a single pulse arriving exactly as valid rises
    always @(negedge clk) begin
        if (rst_n && go) begin
            goCount++;
            checkOutput("go_with_valid_rise", {14'd0, valid, prevValid}, 16'h0002);
        end
        prevValid = valid;
    end

    initial begin
        vecs[0] = '{sw: 2'b10, cin: 1'b0, expOut: 10'b1000000001, expGo: 0};
        vecs[1] = '{sw: 2'b01, cin: 1'b0, expOut: 10'b1001000010, expGo: 0};
        vecs[2] = '{sw: 2'b11, cin: 1'b1, expOut: 10'b1001111111, expGo: 1};
        vecs[3] = '{sw: 2'b00, cin: 1'b0, expOut: 10'b0001111001, expGo: 1};
        vecs[4] = '{sw: 2'b11, cin: 1'b0, expOut: 10'b0011111010, expGo: 1};
        vecs[5] = '{sw: 2'b01, cin: 1'b0, expOut: 10'b0011010111, expGo: 2};

        rst_n    = 1'b0;
        sw       = 2'b00;
        cin_sw   = 1'b0;
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {5'd0, go, packOut()}, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Load sequence, wrap from READY and a second full set
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].sw, vecs[i].cin);
            checkOutput($sformatf("vec%0d_outputs", i), {6'd0, packOut()}, {6'd0, vecs[i].expOut});
            checkOutput($sformatf("vec%0d_go_count", i), 16'(goCount), 16'(vecs[i].expGo));
        end

        // Exact press latency: capture on edge DB+3
        resetDut();
        @(negedge clk);
        sw       = 2'b11;
        btn_load = 1'b1;
        for (int k = 1; k <= DB + 3; k++) begin
            @(posedge clk);
            #1;
            if (k < DB + 3)
                checkOutput($sformatf("latency_edge%0d_hold", k), {12'd0, state, a1, a0}, 16'h0000);
            else
                checkOutput("latency_capture_edge", {12'd0, state, a1, a0}, 16'h0007);
        end
        @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);

        // Short pulse rejected, long hold with a low glitch gives one step
        resetDut();
        @(negedge clk);
        sw       = 2'b11;
        btn_load = 1'b1;
        repeat (DB - 1) @(negedge clk);
        btn_load = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("short_pulse_state", {14'd0, state}, 16'h0000);
        btn_load = 1'b1;
        repeat (20) @(negedge clk);
        btn_load = 1'b0;
        repeat (2) @(negedge clk);
        btn_load = 1'b1;
        repeat (28) @(negedge clk);
        checkOutput("hold_glitch_state", {14'd0, state}, 16'h0001);
        btn_load = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("hold_release_outputs", {6'd0, packOut()}, {6'd0, 10'b1100000001});

        // Clear arriving on the capture edge of the GET_OP press
        resetDut();
        applyStimulus(2'b10, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("pre_clear_state", {14'd0, state}, 16'h0002);
        goBase = goCount;
        @(negedge clk);
        sw       = 2'b11;
        cin_sw   = 1'b1;
        btn_load = 1'b1;
        repeat (DB) @(negedge clk);
        btn_clr = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("clear_outputs", {6'd0, packOut()}, 16'h0000);
        btn_clr = 1'b0;
        repeat (4) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_clear_outputs", {6'd0, packOut()}, 16'h0000);
        checkOutput("clear_no_go", 16'(goCount), 16'(goBase));

        // Asynchronous reset in the middle of a debounce count
        resetDut();
        applyStimulus(2'b10, 1'b0);
        @(negedge clk);
        sw       = 2'b01;
        btn_load = 1'b1;
        repeat (DB) @(posedge clk);
        #2;
        checkOutput("pre_async_reset", {6'd0, packOut()}, {6'd0, 10'b1000000001});
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", {5'd0, go, packOut()}, 16'h0000);
        btn_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("no_spurious_press", {6'd0, packOut()}, 16'h0000);
        applyStimulus(2'b01, 1'b0);
        checkOutput("repress_after_reset", {6'd0, packOut()}, {6'd0, 10'b0100000001});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
